// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Finite-state sequencer for a multicycle MIPS-subset datapath. A single ALU
//   and a single memory port are shared across cycles, so every instruction is
//   walked through 3-5 states (plus memory wait cycles). The block decodes
//   per-cycle enables and mux selects from the registered state, counts
//   retired instructions and keeps a sticky fault flag for illegal
//   instructions and memory-handshake timeouts.
//
// Parameters:
//   TIMEOUT - maximum cycles spent waiting on mem_ready in one memory state
//   CNT_W   - width of instr_count
//
// Ports:
//   clk, rst          - clock (rising edge) and asynchronous active-low reset
//   opcode, funct     - instruction fields from the instruction register
//   zero              - ALU zero flag (branch decision)
//   mem_ready         - memory completes the current access this cycle
//   pc_write, pc_src  - PC load strobe and PC source select
//   iord              - memory address select (0 = PC, 1 = ALU result)
//   mem_read/mem_write- memory strobes
//   ir_write          - instruction register load strobe
//   reg_write         - register file write enable
//   reg_dst           - write register select (0 = rt, 1 = rd)
//   mem_to_reg        - write data select (0 = ALU, 1 = memory)
//   alu_src_a/b       - ALU operand selects
//   alu_ctrl          - ALU operation (add/sub/and/or)
//   state             - current state encoding (debug)
//   instr_count       - retired-instruction counter (wraps)
//   fault             - sticky illegal-instruction / memory-timeout flag
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_ctrl,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             fault
);

  // The wait counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT is
  // detected one step early and the counter clears instead of storing it.
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIWB   = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fault_q, fault_d;

  // Raw decode before reset gating of the strobes.
  logic       pc_write_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c;
  logic       mem_state, retire, illegal_hit, timeout;

  // R-type function decode, shared by EXEC and RWB (RWB holds the ALU setup).
  logic       funct_ok;
  logic [1:0] funct_alu;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      default: funct_ok  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = S_FETCH;       // unlisted encodings fall back to FETCH
    pc_write_c  = 1'b0;
    pc_src      = PC_ALU;
    iord        = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_ctrl    = ALU_ADD;
    mem_state   = 1'b0;
    retire      = 1'b0;
    illegal_hit = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_state  = 1'b1;
        mem_read_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        alu_src_b = SRCB_IMM2;
        case (opcode)
          OP_LW, OP_SW, OP_ADDI: state_d = S_MEMADDR;
          OP_RTYPE:              state_d = S_EXEC;
          OP_BEQ:                state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          default:               state_d = S_ILLEGAL;
        endcase
      end

      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW:   state_d = S_MEMREAD;
          OP_SW:   state_d = S_MEMWRITE;
          OP_ADDI: state_d = S_ADDIWB;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMREAD: begin
        mem_state  = 1'b1;
        iord       = 1'b1;
        mem_read_c = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_d    = mem_ready ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_state   = 1'b1;
        iord        = 1'b1;
        mem_write_c = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        retire      = mem_ready;
        state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_ctrl  = funct_alu;
        state_d   = funct_ok ? S_RWB : S_ILLEGAL;
      end

      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_REG;
        alu_ctrl    = funct_alu;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_ADDIWB: begin
        reg_write_c = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_ctrl   = ALU_SUB;
        pc_src     = PC_BRANCH;
        pc_write_c = zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_write_c = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_ILLEGAL: begin
        illegal_hit = 1'b1;
        state_d     = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // A late mem_ready on the last allowed cycle wins, because timeout is
    // only raised while mem_ready is low.
    timeout = mem_state && !mem_ready && (wait_q == WAIT_LAST);
    if (timeout) begin
      state_d = S_FETCH;
    end

    // Non-memory states always hold zero, so every entry into a memory state
    // (including re-entry of FETCH after a timeout) starts from zero.
    wait_d  = (mem_state && !mem_ready && !timeout) ? wait_q + WAIT_W'(1) : '0;
    fault_d = fault_q | illegal_hit | timeout;
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  // Strobes are gated by reset directly so a write in flight is withdrawn in
  // the same cycle reset falls, not at the next edge.
  assign pc_write    = pc_write_c  & rst;
  assign mem_read    = mem_read_c  & rst;
  assign mem_write   = mem_write_c & rst;
  assign ir_write    = ir_write_c  & rst;
  assign reg_write   = reg_write_c & rst;

  assign state       = state_q;
  assign instr_count = count_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Drives whole instructions through multicycle_ctrl and compares every cycle
// against a reference built from instruction-level rules: each instruction is
// expanded into its list of visited states, the bench decides how many wait
// cycles each memory state sees, and expected outputs come from a per-state
// table. Retirement count and the sticky fault are tracked per instruction.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 32;

  localparam int ST_F   = 0;
  localparam int ST_D   = 1;
  localparam int ST_MA  = 2;
  localparam int ST_MR  = 3;
  localparam int ST_MWB = 4;
  localparam int ST_MW  = 5;
  localparam int ST_EX  = 6;
  localparam int ST_RWB = 7;
  localparam int ST_BR  = 8;
  localparam int ST_J   = 9;
  localparam int ST_AWB = 10;
  localparam int ST_ILL = 11;

  // Ready policies for run_instr.
  localparam int RDY_ALWAYS   = 0;
  localparam int RDY_RANDOM   = 1;
  localparam int RDY_LOW_DATA = 2;  // first n_low data-memory cycles low
  localparam int RDY_LOW_IF   = 3;  // first n_low FETCH cycles low

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          pc_write, iord, mem_read, mem_write, ir_write;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]    pc_src, alu_src_b, alu_ctrl;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  logic          fault;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl;
  } ctrl_t;

  ctrl_t act;
  assign act = {pc_write, pc_src, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl};

  int          errors = 0;
  int          checks = 0;
  int unsigned m_count = 0;
  bit          m_fault = 1'b0;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctrl    (alu_ctrl),
    .state       (state),
    .instr_count (instr_count),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected control word for one cycle spent in state st.
  function automatic ctrl_t expect_ctrl(input int st, input bit rdy, input bit z,
                                        input logic [5:0] fn);
    ctrl_t      e;
    logic [1:0] r_op;
    e = '0;
    r_op = (fn == 6'h22) ? 2'b01 : (fn == 6'h24) ? 2'b10 :
           (fn == 6'h25) ? 2'b11 : 2'b00;
    case (st)
      ST_F:   begin e.mem_read = 1; e.alu_src_b = 2'b01;
                    e.ir_write = rdy; e.pc_write = rdy; end
      ST_D:   e.alu_src_b = 2'b11;
      ST_MA:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      ST_MR:  begin e.iord = 1; e.mem_read = 1; e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      ST_MWB: begin e.reg_write = 1; e.mem_to_reg = 1; end
      ST_MW:  begin e.iord = 1; e.mem_write = 1; e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      ST_EX:  begin e.alu_src_a = 1; e.alu_ctrl = r_op; end
      ST_RWB: begin e.reg_write = 1; e.reg_dst = 1; e.alu_src_a = 1; e.alu_ctrl = r_op; end
      ST_BR:  begin e.alu_src_a = 1; e.alu_ctrl = 2'b01; e.pc_src = 2'b01; e.pc_write = z; end
      ST_J:   begin e.pc_src = 2'b10; e.pc_write = 1; end
      ST_AWB: begin e.reg_write = 1; e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25;
  endfunction

  task automatic check_totals(input string tag);
    checks++;
    if (instr_count !== CW'(m_count)) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", tag, instr_count, m_count);
    end
    checks++;
    if (fault !== m_fault) begin
      errors++;
      $display("FAIL %s fault: got %0b expected %0b", tag, fault, m_fault);
    end
    checks++;
    if (state !== 4'(ST_F)) begin
      errors++;
      $display("FAIL %s end state: got %0d expected 0", tag, state);
    end
  endtask

  // Runs one instruction from FETCH back to FETCH. Called at posedge+1.
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input bit z,
                           input int mode, input int n_low);
    int    path[$];
    int    idx = 0;
    int    waitc = 0;
    int    low_left = n_low;
    int    guard = 0;
    int    cur;
    bit    done = 0;
    bit    rdy;
    bit    is_mem;
    bit    gated;
    ctrl_t exp_c;

    opcode = op;
    funct  = fn;
    zero   = z;
    path.push_back(ST_F);
    path.push_back(ST_D);
    case (op)
      6'h23: begin path.push_back(ST_MA); path.push_back(ST_MR); path.push_back(ST_MWB); end
      6'h2B: begin path.push_back(ST_MA); path.push_back(ST_MW); end
      6'h08: begin path.push_back(ST_MA); path.push_back(ST_AWB); end
      6'h00: begin path.push_back(ST_EX); path.push_back(funct_legal(fn) ? ST_RWB : ST_ILL); end
      6'h04: path.push_back(ST_BR);
      6'h02: path.push_back(ST_J);
      default: path.push_back(ST_ILL);
    endcase

    while (!done && guard < 400) begin
      guard++;
      cur    = path[idx];
      is_mem = (cur == ST_F) || (cur == ST_MR) || (cur == ST_MW);
      gated  = (mode == RDY_LOW_DATA && (cur == ST_MR || cur == ST_MW)) ||
               (mode == RDY_LOW_IF && cur == ST_F);
      if (!is_mem)                 rdy = 1'($urandom_range(0, 1));
      else if (gated)              rdy = (low_left == 0);
      else if (mode == RDY_RANDOM) rdy = ($urandom_range(0, 3) != 0);
      else                         rdy = 1'b1;
      if (gated && low_left > 0) low_left--;
      mem_ready = rdy;

      @(negedge clk);
      checks++;
      if (state !== 4'(cur)) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", tag, state, cur);
      end
      exp_c = expect_ctrl(cur, rdy, z, fn);
      checks++;
      if (act !== exp_c) begin
        errors++;
        $display("FAIL %s ctrl in state %0d: got %h expected %h", tag, cur, act, exp_c);
      end

      if (is_mem && !rdy) begin
        waitc++;
        if (waitc == TO) begin
          m_fault = 1'b1;  // memory timeout: abandon instruction, no retire
          done    = 1'b1;
        end
      end else begin
        waitc = 0;
        if (idx == path.size() - 1) begin
          done = 1'b1;
          if (cur == ST_ILL) m_fault = 1'b1;
          else               m_count++;
        end else begin
          idx++;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s cycle budget: got unfinished expected finished", tag);
    end
    check_totals(tag);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h20;
    zero      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b1;
    m_count = 0;
    m_fault = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    mem_ready = 1'b1;  // FETCH strobes must still be held low
    opcode    = 6'h23;
    funct     = 6'h20;
    zero      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset state: got %0d expected 0", state); end
    checks++;
    if (instr_count !== '0) begin errors++; $display("FAIL reset count: got %0d expected 0", instr_count); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset fault: got %0b expected 0", fault); end
    checks++;
    if ({pc_write, ir_write, reg_write, mem_read, mem_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset strobes: got %b expected 00000",
               {pc_write, ir_write, reg_write, mem_read, mem_write});
    end
    @(posedge clk);
    #1;
    rst     = 1'b1;
    m_count = 0;
    m_fault = 1'b0;
  endtask

  task automatic test_add();
    run_instr("add", 6'h00, 6'h20, 1'b0, RDY_ALWAYS, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", 6'h23, 6'h11, 1'b1, RDY_LOW_DATA, 3);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'h04, 6'h00, 1'b1, RDY_ALWAYS, 0);
    run_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, RDY_ALWAYS, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'h3F, 6'h20, 1'b0, RDY_ALWAYS, 0);
    run_instr("illegal_funct", 6'h00, 6'h00, 1'b0, RDY_ALWAYS, 0);
    run_instr("j_after_fault", 6'h02, 6'h00, 1'b0, RDY_ALWAYS, 0);
  endtask

  task automatic test_reset_mid();
    opcode    = 6'h2B;
    funct     = 6'h20;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || state !== 4'(ST_MW)) begin
      errors++;
      $display("FAIL mid_reset setup: got state %0d mem_write %0b expected state 5 mem_write 1",
               state, mem_write);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL mid_reset mem_write: got %0b expected 0", mem_write); end
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL mid_reset state: got %0d expected 0", state); end
    checks++;
    if (instr_count !== '0) begin errors++; $display("FAIL mid_reset count: got %0d expected 0", instr_count); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL mid_reset fault: got %0b expected 0", fault); end
    @(posedge clk);
    #1;
    rst     = 1'b1;
    m_count = 0;
    m_fault = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    run_instr("timeout_fetch", 6'h02, 6'h00, 1'b0, RDY_LOW_IF, TO);
    do_reset();
    run_instr("ready_on_last", 6'h02, 6'h00, 1'b0, RDY_LOW_IF, TO - 1);
    do_reset();
    run_instr("timeout_sw", 6'h2B, 6'h00, 1'b0, RDY_LOW_DATA, TO);
    run_instr("sw_last_cycle", 6'h2B, 6'h00, 1'b0, RDY_LOW_DATA, TO - 1);
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00};
    logic [5:0] op, fn;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr("random", op, fn, 1'($urandom_range(0, 1)), RDY_RANDOM, 0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Finite-state sequencer that drives the shared ALU, register file and data memory as a multicycle MIPS-subset datapath.
- One ALU and one memory port are reused across cycles, so each instruction takes 3–5 states plus any memory wait cycles.
- Sits beside `control`. It consumes opcode, funct, ALU zero and a memory ready handshake, and emits per-cycle enables and mux selects.
- It also keeps a retired-instruction counter and a sticky bus-fault flag.

Parameters:
- TIMEOUT, 255: maximum cycles spent waiting on mem_ready in any single memory state before a fault.
- CNT_W, 32: width of instr_count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26], taken from the instruction register.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag, used in the BRANCH state.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 00 = ALU result, 01 = branch target, 10 = jump target.
- iord  out  1  memory address source: 0 = PC, 1 = ALU result.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  load instruction register.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-data select: 0 = ALU result, 1 = memory data.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = regOut1.
- alu_src_b  out  2  ALU operand B: 00 = regOut2, 01 = constant 4, 10 = immValue, 11 = immValue<<2.
- alu_ctrl  out  2  ALU operation: 00 = add, 01 = sub, 10 = and, 11 = or.
- state  out  4  current state encoding, for debug.
- instr_count  out  CNT_W  count of retired instructions.
- fault  out  1  sticky flag: illegal instruction or memory timeout.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIWB=10, ILLEGAL=11.
- Any encoding not listed goes to FETCH on the next edge.
- Reset: while rst=0, the following hold.
  - state=FETCH, instr_count=0, fault=0, wait counter=0.
  - Every strobe (pc_write, ir_write, reg_write, mem_read, mem_write) is forced to 0.
- Outputs are decoded combinationally from the registered state, plus mem_ready/zero where noted. Any output not listed for a state is 0.
- FETCH:
  - Outputs: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_ctrl=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - When mem_ready=1, go to DECODE; otherwise stay in FETCH.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_ctrl=00 (precomputes the branch target).
  - Next state by opcode: 0x23 (lw) and 0x2B (sw) -> MEMADDR; 0x00 -> EXEC; 0x04 (beq) -> BRANCH; 0x02 (j) -> JUMP; 0x08 (addi) -> MEMADDR; anything else -> ILLEGAL.
- MEMADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_ctrl=00.
  - Next state: lw -> MEMREAD, sw -> MEMWRITE, addi -> ADDIWB.
- MEMREAD:
  - Outputs: iord=1, mem_read=1; ALU outputs held as in MEMADDR.
  - Go to MEMWB on mem_ready.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
- MEMWRITE:
  - Outputs: iord=1, mem_write=1; ALU outputs held.
  - Go to FETCH on mem_ready.
- EXEC:
  - Outputs: alu_src_a=1, alu_src_b=00.
  - alu_ctrl by funct: 0x20 -> 00, 0x22 -> 01, 0x24 -> 10, 0x25 -> 11.
  - Any other funct -> ILLEGAL instead of RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0; ALU outputs held; then FETCH.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; ALU outputs as in MEMADDR; then FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_ctrl=01, pc_src=01, pc_write=zero.
  - Then FETCH.
- JUMP: pc_src=10, pc_write=1; then FETCH.
- ILLEGAL: no strobes; fault is set to 1; then FETCH. The instruction is not counted.
- Retirement: instr_count increments by 1 (wrapping modulo 2^CNT_W) on the edge that leaves any of these: MEMWB, MEMWRITE (with mem_ready=1), RWB, ADDIWB, BRANCH, JUMP.
- Memory wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments on each cycle spent in one of those states with mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0: fault is set to 1, state goes to FETCH, the counter clears, and the instruction does not retire.
  - mem_ready=1 on the TIMEOUT cycle itself wins: a normal transition, no fault.
- fault clears only on reset.
- Reset asserted mid-instruction: state returns to FETCH immediately and strobes drop combinationally; no partial write completes after rst falls.

Test Plan:
- Reset, then add (opcode 0x00, funct 0x20), mem_ready tied to 1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 in RWB; instr_count=1.
- lw (0x23) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with iord=1 and mem_read=1; MEMWB has mem_to_reg=1; count increments once.
- beq (0x04): once with zero=1 and once with zero=0 -> pc_write=1 with pc_src=01 only when zero=1; both retire; count=2.
- opcode 0x3F, then R-type with funct 0x00 -> both reach ILLEGAL; fault=1; instr_count unchanged; fault stays 1 after a following valid j.
- TIMEOUT=4 and mem_ready held 0 in FETCH -> fault set after 4 waiting cycles, state returns to FETCH. Same test with mem_ready=1 on cycle 4 -> DECODE, fault=0.
- Drive rst low during MEMWRITE with mem_ready=0 -> mem_write drops the same cycle; state=0, instr_count=0, fault=0.
